// File: rtl/sha_round_seq.sv
// sha_round_seq: sequencer for one SHA-256 compression of a 512-bit block.
// The round arithmetic lives in an external single-round datapath. This block
// feeds that datapath (rnd_in/rnd_k/rnd_w) for 64 rounds, expands the message
// schedule in a sliding 16-word window, and adds the final datapath state
// back onto the chaining value.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     job handshake; in_chain {a..h}, in_block W0 at [511:480]
//   out_valid/out_ready   digest handshake; out_digest packed like in_chain
//   busy                  high whenever a job is in flight
//   rnd_in/rnd_k/rnd_w    operands to the round datapath
//   rnd_out               datapath result, registered one clock after its operands
module sha_round_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_chain,
    input  logic [511:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy,
    output logic [255:0] rnd_in,
    output logic [31:0]  rnd_k,
    output logic [31:0]  rnd_w,
    input  logic [255:0] rnd_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [1:0]   r_state;
    logic [5:0]   r_t;
    logic [255:0] r_chain;
    logic [31:0]  r_w [0:15];
    logic [255:0] r_digest;

    logic [31:0]  w_next_w;
    logic [255:0] w_final;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window holds W[t..t+15]; this produces W[t+16].
    assign w_next_w = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];

    // Per-word add, no carry across the 32-bit lanes.
    always_comb begin
        w_final = '0;
        for (int i = 0; i < 8; i++) begin
            w_final[i*32 +: 32] = r_chain[i*32 +: 32] + rnd_out[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_t      <= '0;
            r_chain  <= '0;
            r_digest <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_chain <= in_chain;
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= in_block[511 - 32*i -: 32];
                        end
                        r_t     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i+1];
                    end
                    r_w[15] <= w_next_w;
                    r_t     <= r_t + 6'd1;
                    if (r_t == 6'd63) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    // rnd_out now carries the result of round 63.
                    r_digest <= w_final;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (r_state == ST_IDLE);
        out_valid  = (r_state == ST_DONE);
        busy       = (r_state != ST_IDLE);
        out_digest = r_digest;
        rnd_in     = r_chain;
        rnd_k      = '0;
        rnd_w      = '0;
        if (r_state == ST_RUN) begin
            // Round 0 starts from the chaining value; later rounds chain the
            // datapath's own registered result.
            rnd_in = (r_t == 6'd0) ? r_chain : rnd_out;
            rnd_k  = K_TAB[r_t];
            rnd_w  = r_w[0];
        end
    end

endmodule

// File: tb/tb_sha_round_seq.sv
// Bench for sha_round_seq: includes a behavioural SHA-256 round datapath,
// directed known-answer vectors, and a queue scoreboard checked on handshake.
module tb_sha_round_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_chain = '0;
    logic [511:0] in_block = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_digest;
    logic         busy;
    logic [255:0] rnd_in;
    logic [31:0]  rnd_k;
    logic [31:0]  rnd_w;
    logic [255:0] rnd_out = '0;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q [$];

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] TWO_BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_MID = {32'h85e655d6, 32'h417a1795, 32'h3363376a, 32'h624cde5c,
                                        32'h76e09589, 32'hcac5f811, 32'hcc4b32c1, 32'hf20e533a};
    localparam logic [255:0] TWO_DIG = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    sha_round_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_chain   (in_chain),
        .in_block   (in_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest),
        .busy       (busy),
        .rnd_in     (rnd_in),
        .rnd_k      (rnd_k),
        .rnd_w      (rnd_w),
        .rnd_out    (rnd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // External registered round datapath.
    always @(posedge clk) rnd_out <= sha_round(rnd_in, rnd_k, rnd_w);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every digest handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_digest", out_digest, '0);
                if (out_digest == '0) begin
                    errors++;
                    $display("FAIL unexpected_digest: got handshake expected none");
                end
            end else begin
                chk("digest", out_digest, exp_q.pop_front());
            end
        end
    end

    task automatic accept_job(input logic [255:0] chain, input logic [511:0] blk,
                              input logic [255:0] exp);
        int waited = 0;
        while (!in_ready && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("in_ready_before_accept", {255'h0, in_ready}, 256'h1);
        in_chain = chain;
        in_block = blk;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
    endtask

    task automatic run_job(input logic [255:0] chain, input logic [511:0] blk,
                           input logic [255:0] exp, input bit abc_checks, input int hold);
        int n = 0;
        out_ready = (hold == 0);
        accept_job(chain, blk, exp);
        // Keep in_valid asserted through a held job to show it is ignored.
        in_valid = (hold > 0);
        chk("in_ready_run", {255'h0, in_ready}, 256'h0);
        chk("busy_run", {255'h0, busy}, 256'h1);
        while (!out_valid && n < 100) begin
            if (abc_checks) begin
                if (n == 0) begin
                    chk("rnd_k_first", {224'h0, rnd_k}, {224'h0, 32'h428a2f98});
                    chk("rnd_w_first", {224'h0, rnd_w}, {224'h0, 32'h61626380});
                    chk("rnd_in_first", rnd_in, chain);
                end
                if (n == 15) chk("rnd_w_16th", {224'h0, rnd_w}, {224'h0, 32'h00000018});
                if (n == 63) chk("rnd_k_last", {224'h0, rnd_k}, {224'h0, 32'hc67178f2});
                if (n == 64) chk("rnd_k_final", {224'h0, rnd_k}, 256'h0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 256'(n), 256'd65);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {255'h0, out_valid}, 256'h1);
            chk("hold_digest", out_digest, exp);
            chk("hold_in_ready", {255'h0, in_ready}, 256'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_hs_valid", {255'h0, out_valid}, 256'h0);
        chk("post_hs_in_ready", {255'h0, in_ready}, 256'h1);
        chk("post_hs_digest_kept", out_digest, exp);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {255'h0, out_valid}, 256'h0);
        chk("rst_digest", out_digest, '0);
        chk("rst_busy", {255'h0, busy}, 256'h0);
        chk("rst_in_ready", {255'h0, in_ready}, 256'h1);
        chk("rst_rnd_in", rnd_in, '0);
        chk("rst_rnd_k", {224'h0, rnd_k}, 256'h0);
        #30 rst = 1'b0;

        run_job(IV, ABC_BLK, ABC_DIG, 1'b1, 0);
        run_job(IV, TWO_BLK1, TWO_MID, 1'b0, 0);
        run_job(TWO_MID, TWO_BLK2, TWO_DIG, 1'b0, 0);
        run_job(IV, ABC_BLK, ABC_DIG, 1'b0, 10);

        // Abort a job mid-run with reset.
        accept_job(IV, ABC_BLK, ABC_DIG);
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rnd_k_round30", {224'h0, rnd_k}, {224'h0, 32'h06ca6351});
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_out_valid", {255'h0, out_valid}, 256'h0);
        chk("abort_digest", out_digest, '0);
        chk("abort_in_ready", {255'h0, in_ready}, 256'h1);
        chk("abort_busy", {255'h0, busy}, 256'h0);
        #20 rst = 1'b0;
        run_job(IV, ABC_BLK, ABC_DIG, 1'b1, 0);

        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
